mul_div_sequencer: RTL

MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

---
 rtl/mul_div_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: multi-cycle MIPS-style HI/LO multiply/divide unit.
// Optional feature: define MULDIV_DIV_EN to build in divide support
// (ops 10 div, 11 divu). Without it those ops are ignored at start.
//
// Handshake: start is sampled only while the unit is idle (busy low); the
// accepting edge latches op/A/B and raises busy for exactly 34 cycles
// (PREP 1, RUN 32, FIX 1). The edge leaving FIX updates hi/lo, drops busy
// and raises done for a single cycle. There is no queuing: start while busy
// is dropped. Direct HI/LO loads (writeHi/writeLo) only act while idle and
// lose to a start accepted in the same cycle.
module mul_div_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        writeHi,
  input  logic        writeLo,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        uns_q;
  logic        neg_q;
  logic [31:0] op2_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
`ifdef MULDIV_DIV_EN
  logic        div_q;
  logic        rneg_q;
  logic [32:0] rem33;
`endif

  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] op2_d;
  logic [63:0] acc_init;
  logic [63:0] acc_d;
  logic [32:0] sum33;
  logic [63:0] prod;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Start is only taken when idle; divide ops are refused when divide is not built in.
  always_comb begin
    accept = 1'b0;
`ifdef MULDIV_DIV_EN
    if (state_q == IDLE && start) accept = 1'b1;
`else
    if (state_q == IDLE && start && !op[1]) accept = 1'b1;
`endif
  end

  // Operand magnitudes and accumulator seed for the first RUN step.
  always_comb begin
    a_mag    = (!uns_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    b_mag    = (!uns_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    op2_d    = a_mag;
    acc_init = {32'd0, b_mag};
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      op2_d    = b_mag;
      acc_init = {32'd0, a_mag};
    end
`endif
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    sum33 = {1'b0, acc_q[63:32]} + {1'b0, op2_q};
    if (acc_q[0]) acc_d = {sum33, acc_q[31:1]};
    else          acc_d = {1'b0, acc_q[63:1]};
`ifdef MULDIV_DIV_EN
    rem33 = acc_q[63:31];
    if (div_q) begin
      if (rem33 >= {1'b0, op2_q}) acc_d = {rem33[31:0] - op2_q, acc_q[30:0], 1'b1};
      else                        acc_d = {acc_q[62:0], 1'b0};
    end
`endif
  end

  // Sign correction and special cases applied to the final accumulator.
  always_comb begin
    prod   = neg_q ? (64'd0 - acc_q) : acc_q;
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      if (b_q == 32'd0) begin
        fix_hi = a_q;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_lo = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
        fix_hi = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      end
    end
`endif
  end

  // Sequencer FSM with registered busy/done and the HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      uns_q   <= 1'b0;
      neg_q   <= 1'b0;
      op2_q   <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            uns_q   <= op[0];
`ifdef MULDIV_DIV_EN
            div_q   <= op[1];
`endif
            busy_q  <= 1'b1;
            state_q <= PREP;
          end else begin
            if (writeHi) hi_q <= writeData;
            if (writeLo) lo_q <= writeData;
          end
        end
        PREP: begin
          op2_q   <= op2_d;
          acc_q   <= acc_init;
          neg_q   <= !uns_q && (a_q[31] ^ b_q[31]);
`ifdef MULDIV_DIV_EN
          rneg_q  <= !uns_q && a_q[31];
`endif
          cnt_q   <= 5'd0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule
